// File: rtl/core_dmem_responder_pkg.sv
// ============================================================================
// core_dmem_responder_pkg
// Shared bus widths and FSM state encoding for the data-memory responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package core_dmem_responder_pkg;

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_STRB_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/core_mem_sram.sv
// ============================================================================
// core_mem_sram
// Single-port synchronous RAM, 64-bit words, byte strobes, 1-cycle read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_mem_sram
    import core_dmem_responder_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [AW-1:0]         addr,
    input  logic [MEM_STRB_W-1:0] strb,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem_q [WORDS];

    // rdata holds its last value on write or idle cycles
    always_ff @(posedge clk) begin
        if (cen) begin
            if (wen) begin
                for (int i = 0; i < MEM_STRB_W; i++) begin
                    if (strb[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem_q[addr];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_dmem_responder.sv
// ============================================================================
// core_dmem_responder
// dmem request/grant responder: wait states, single-cycle grant, range check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_dmem_responder
    import core_dmem_responder_pkg::*;
#(
    parameter int unsigned     MEM_WORDS   = 1024,
    parameter logic [63:0]     BASE_ADDR   = 64'h0000_0000_0001_0000,
    parameter int unsigned     WAIT_CYCLES = 1
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  dmem_req,
    input  logic [MEM_ADDR_W-1:0] dmem_addr,
    input  logic                  dmem_wen,
    input  logic [MEM_STRB_W-1:0] dmem_strb,
    input  logic [MEM_DATA_W-1:0] dmem_wdata,
    output logic                  dmem_gnt,
    output logic                  dmem_err,
    output logic [MEM_DATA_W-1:0] dmem_rdata
);

    localparam int unsigned     IDX_W     = $clog2(MEM_WORDS);
    localparam logic [63:0]     SPAN      = 64'(MEM_WORDS) << 3;
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  wen_q;
    logic [MEM_STRB_W-1:0] strb_q;
    logic [MEM_DATA_W-1:0] wdata_q;
    logic                  in_range_q;

    logic                  capture;
    logic                  rd_issue;
    logic                  wr_commit;
    logic                  in_range;
    logic [MEM_ADDR_W-1:0] offset;
    logic [IDX_W-1:0]      sram_addr;
    logic [MEM_DATA_W-1:0] sram_rdata;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range
    assign offset   = dmem_addr - BASE_ADDR;
    assign in_range = (offset < SPAN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        rd_issue = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dmem_req) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        rd_issue = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rd_issue = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (capture) begin
            idx_q      <= dmem_addr[3 +: IDX_W];
            wen_q      <= dmem_wen;
            strb_q     <= dmem_strb;
            wdata_q    <= dmem_wdata;
            in_range_q <= in_range;
        end
    end

    // Zero-wait reads are issued from the live bus on the capture cycle
    assign sram_addr = (state_q == ST_IDLE) ? dmem_addr[3 +: IDX_W] : idx_q;
    assign wr_commit = (state_q == ST_RESP) && wen_q && in_range_q && g_resetn;

    core_mem_sram #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_sram (
        .clk   (g_clk),
        .cen   (rd_issue | wr_commit),
        .wen   (wr_commit),
        .addr  (sram_addr),
        .strb  (strb_q),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    assign dmem_gnt   = (state_q == ST_RESP);
    assign dmem_err   = dmem_gnt && !in_range_q;
    assign dmem_rdata = (dmem_gnt && in_range_q && !wen_q) ? sram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder: transaction-level reference model plus
// directed literal checks and a wait-state sweep on extra instances.
`default_nettype none

module tb_core_dmem_responder;

    localparam int          MW   = 64;
    localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
    localparam int          W    = 1;
    localparam logic [63:0] SPAN = 64'(MW) * 64'd8;

    logic        g_clk, g_resetn;
    logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_strb;

    logic [2:0]  req_s, gnt_s, err_s;
    logic [63:0] rdata_s [3];

    int n_tests = 0;
    int n_fail  = 0;

    core_dmem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
    );

    for (genvar k = 0; k < 3; k++) begin : g_sweep
        core_dmem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE),
                              .WAIT_CYCLES((k == 0) ? 0 : ((k == 1) ? 1 : 7))) u_sw (
            .g_clk(g_clk), .g_resetn(g_resetn), .dmem_req(req_s[k]), .dmem_addr(dmem_addr),
            .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
            .dmem_gnt(gnt_s[k]), .dmem_err(err_s[k]), .dmem_rdata(rdata_s[k])
        );
    end

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic bit inr(input logic [63:0] a);
        return (a - BASE) < SPAN;
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r = o;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference model: one outstanding transaction, grant due W+1 cycles after capture
    int          cyc = 0;
    bit          started = 0;
    bit          m_busy = 0;
    int          m_gcyc = 0;
    logic [63:0] m_addr, m_wdata;
    logic        m_wen;
    logic [7:0]  m_strb;
    logic [63:0] mm [MW];

    always @(posedge g_clk) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
        if (!g_resetn) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (cyc == m_gcyc) begin
                m_busy <= 1'b0;
                if (m_wen && inr(m_addr))
                    mm[widx(m_addr)] <= merge(mm[widx(m_addr)], m_wdata, m_strb);
            end
        end else if (dmem_req) begin
            m_busy  <= 1'b1;
            m_gcyc  <= cyc + 1 + W;
            m_addr  <= dmem_addr;
            m_wen   <= dmem_wen;
            m_strb  <= dmem_strb;
            m_wdata <= dmem_wdata;
        end
    end

    logic        e_gnt, e_err;
    logic [63:0] e_rdata;

    always @(negedge g_clk) begin
        if (started) begin
            e_gnt   = m_busy && (cyc == m_gcyc);
            e_err   = e_gnt && !inr(m_addr);
            e_rdata = (e_gnt && !m_wen && inr(m_addr)) ? mm[widx(m_addr)] : 64'd0;
            chk("model_gnt", {63'd0, dmem_gnt}, {63'd0, e_gnt});
            chk("model_err", {63'd0, dmem_err}, {63'd0, e_err});
            chk("model_rdata", dmem_rdata, e_rdata);
        end
    end

    task automatic txn(input logic [63:0] a, input logic w, input logic [7:0] s,
                       input logic [63:0] d, input bit drop,
                       output logic e, output logic [63:0] r);
        int n;
        bit got;
        n = 0; got = 0; e = 1'b0; r = 64'd0;
        @(posedge g_clk); #1;
        dmem_req = 1'b1; dmem_addr = a; dmem_wen = w; dmem_strb = s; dmem_wdata = d;
        @(posedge g_clk); #1;
        // Bus is scrambled after capture; the responder must ignore it
        dmem_addr  = {$urandom, $urandom};
        dmem_wdata = {$urandom, $urandom};
        dmem_strb  = 8'($urandom);
        dmem_wen   = 1'($urandom);
        if (drop) dmem_req = 1'b0;
        while (!got && n < 64) begin
            @(negedge g_clk);
            n++;
            if (dmem_gnt) begin
                got = 1'b1; e = dmem_err; r = dmem_rdata;
            end
        end
        chk("gnt_seen", 64'(got), 64'd1);
        @(posedge g_clk); #1;
        dmem_req = 1'b0;
    endtask

    task automatic sweep(input int k, input int w);
        int n, last, ng;
        n = 0; last = 0; ng = 0;
        @(posedge g_clk); #1;
        req_s[k] = 1'b1;
        while (ng < 3 && n < 80) begin
            @(negedge g_clk);
            n++;
            if (gnt_s[k]) begin
                if (ng == 0) chk($sformatf("sweep_w%0d_latency", w), 64'(n), 64'(w + 2));
                else         chk($sformatf("sweep_w%0d_interval", w), 64'(n - last), 64'(w + 2));
                chk($sformatf("sweep_w%0d_err", w), {63'd0, err_s[k]}, 64'd0);
                last = n;
                ng++;
            end
        end
        chk($sformatf("sweep_w%0d_grants", w), 64'(ng), 64'd3);
        @(posedge g_clk); #1;
        req_s[k] = 1'b0;
        repeat (w + 3) @(posedge g_clk);
    endtask

    logic        e;
    logic [63:0] r, a;
    int          n, g;
    bit          got;

    initial begin
        req_s = 3'b000;
        g_resetn = 1'b0;
        dmem_req = 1'b1; dmem_addr = BASE; dmem_wen = 1'b1;
        dmem_strb = 8'hFF; dmem_wdata = 64'h1111_2222_3333_4444;
        repeat (3) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge g_clk);
            n++;
            if (dmem_gnt) got = 1'b1;
        end
        chk("reset_first_gnt_cycle", 64'(n), 64'(W + 2));
        @(posedge g_clk); #1;
        dmem_req = 1'b0;

        for (int i = 1; i < MW; i++) begin
            txn(BASE + 64'(i) * 8, 1'b1, 8'hFF,
                (i == MW - 1) ? 64'h5555_6666_7777_8888 : {$urandom, $urandom}, 1'b0, e, r);
        end

        txn(BASE + 64'h18, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, e, r);
        chk("full_write_err", {63'd0, e}, 64'd0);
        txn(BASE + 64'h18, 1'b0, 8'h00, 64'd0, 1'b0, e, r);
        chk("full_read_err", {63'd0, e}, 64'd0);
        chk("full_read_data", r, 64'h0123_4567_89AB_CDEF);

        txn(BASE + 64'h30, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, e, r);
        txn(BASE + 64'h30, 1'b1, 8'h0F, 64'd0, 1'b0, e, r);
        txn(BASE + 64'h33, 1'b0, 8'h00, 64'd0, 1'b0, e, r);
        chk("partial_read_data", r, 64'hFFFF_FFFF_0000_0000);

        txn(BASE + SPAN, 1'b0, 8'h00, 64'd0, 1'b0, e, r);
        chk("oor_read_err", {63'd0, e}, 64'd1);
        chk("oor_read_data", r, 64'd0);
        txn(BASE - 64'd8, 1'b1, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, e, r);
        chk("oor_write_err", {63'd0, e}, 64'd1);
        chk("oor_write_data", r, 64'd0);
        txn(BASE, 1'b0, 8'h00, 64'd0, 1'b0, e, r);
        chk("word0_unchanged", r, 64'h1111_2222_3333_4444);
        txn(BASE + SPAN - 64'd8, 1'b0, 8'h00, 64'd0, 1'b0, e, r);
        chk("last_word_unchanged", r, 64'h5555_6666_7777_8888);

        txn(BASE + 64'h20, 1'b1, 8'hFF, 64'hCAFE_F00D_CAFE_F00D, 1'b0, e, r);
        @(posedge g_clk); #1;
        dmem_req = 1'b1; dmem_addr = BASE + 64'h20; dmem_wen = 1'b1;
        dmem_strb = 8'hFF; dmem_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge g_clk); #1;
        g_resetn = 1'b0; dmem_req = 1'b0;
        g = 0;
        @(negedge g_clk); g += int'(dmem_gnt);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        repeat (4) begin @(negedge g_clk); g += int'(dmem_gnt); end
        chk("midreset_no_gnt", 64'(g), 64'd0);
        txn(BASE + 64'h20, 1'b0, 8'h00, 64'd0, 1'b0, e, r);
        chk("midreset_mem_unchanged", r, 64'hCAFE_F00D_CAFE_F00D);

        txn(BASE + 64'h28, 1'b1, 8'hFF, 64'hBEEF_0000_BEEF_1111, 1'b1, e, r);
        chk("drop_err", {63'd0, e}, 64'd0);
        txn(BASE + 64'h28, 1'b0, 8'h00, 64'd0, 1'b0, e, r);
        chk("drop_write_committed", r, 64'hBEEF_0000_BEEF_1111);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       a = {$urandom, $urandom};
                1:       a = BASE + SPAN + 64'($urandom_range(0, 255));
                2:       a = BASE - 64'($urandom_range(1, 64));
                default: a = BASE + 64'($urandom_range(0, MW - 1)) * 8 + 64'($urandom_range(0, 7));
            endcase
            txn(a, 1'($urandom), 8'($urandom), {$urandom, $urandom},
                ($urandom_range(0, 7) == 0), e, r);
        end

        @(posedge g_clk); #1;
        dmem_addr = BASE; dmem_wen = 1'b0; dmem_strb = 8'h00; dmem_wdata = 64'd0;
        sweep(0, 0);
        sweep(1, 1);
        sweep(2, 7);

        repeat (3) @(posedge g_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
